fft_result_streamer: RTL and testbench
======================================

# fft_result_streamer

Output-side companion to the `FFT` block. When the FFT signals completion, this block snapshots the parallel 64-entry complex result arrays into a local frame buffer. It then streams the samples out one per transfer over a valid/ready interface, with optional bit-reversed reordering. This frees the FFT to accept a new frame while results drain, and gives downstream logic and benches a serial result port instead of two 64×16 buses.

## Interface
- `N`, default 64: points per frame; power of two, minimum 4.
- `W`, default 16: bits per real/imag component.
- `BIT_REVERSE`, default 0: 0 = emit buffer in natural order; 1 = emit buffer entry bitrev(k) as sample k.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `fft_done`  in  1  — one-cycle pulse; `outputRe`/`outputIm` are valid in that same cycle.
- `outputRe`  in  W × [N-1:0]  — FFT real results.
- `outputIm`  in  W × [N-1:0]  — FFT imaginary results.
- `out_valid`  out  1  — sample on `out_re`/`out_im` is valid.
- `out_ready`  in  1  — consumer accepts the sample.
- `out_re`  out  W  — real part of the current sample.
- `out_im`  out  W  — imaginary part of the current sample.
- `out_index`  out  log2(N)  — sample number k within the frame.
- `out_last`  out  1  — high with `out_valid` when k = N-1.
- `busy`  out  1  — a frame is held or streaming.
- `overrun`  out  1  — sticky; set when a `fft_done` is dropped.
- `frame_count`  out  8  — number of frames fully streamed; wraps 255→0.

## Operation
- The state machine has two states: IDLE and STREAM.
- IDLE:
  - `fft_done` = 1 copies all N re/im pairs into the buffer, sets k = 0, and moves to STREAM.
  - `fft_done` = 0: stay in IDLE.
- STREAM:
  - `out_valid` = 1.
  - `out_re`/`out_im` = buffer[k], or buffer[bitrev(k)] when `BIT_REVERSE` = 1.
  - A transfer occurs when `out_valid` && `out_ready`.
  - On a transfer with k < N-1: k increments.
  - On a transfer with k = N-1: `frame_count` increments and the state returns to IDLE, unless `fft_done` is high in the same cycle (see below).
- Back-to-back frames:
  - `fft_done` in the same cycle as the final transfer captures the new frame.
  - The state stays in STREAM with k = 0.
  - No bubble, and `overrun` is not set.
- Dropped frames:
  - `fft_done` in STREAM at any other time is ignored; the buffer is not modified.
  - `overrun` is set to 1 and stays set until `rst`.
- The buffer is written only on capture. Data in the buffer is bit-exact with the FFT outputs; no arithmetic is applied.
- `busy` = (state == STREAM).
- Reset behaviour:
  - `rst` forces IDLE, k = 0, `out_valid` = 0, `out_last` = 0, `busy` = 0, `overrun` = 0, `frame_count` = 0.
  - `out_re`, `out_im`, and `out_index` read 0 while `out_valid` = 0.
  - Buffer contents are not cleared.
  - `rst` mid-stream abandons the frame without incrementing `frame_count`.
  - `rst` takes priority over a simultaneous `fft_done`.

## Timing
- Capture latency: `fft_done` at edge t gives `out_valid` = 1 with k = 0 after edge t, so the first sample is presentable in cycle t+1.
- Throughput: one sample per cycle while `out_ready` is held high; a full frame takes N cycles.
- Hold rule: while `out_valid` && !`out_ready`, `out_re`, `out_im`, `out_index`, and `out_last` are held stable.
- `out_valid` never drops without a transfer, except on `rst`.
- Outputs are registered or decoded only from state, k, and the buffer. There is no combinational path from `out_ready` or `fft_done` to any output.
- `frame_count` and the IDLE transition update on the edge that completes the k = N-1 transfer.

## Test plan
- Basic stream:
  - Stimulus: reset, then `outputRe`[0..31] = 4, [32..63] = 0, all `outputIm` = 0, `fft_done` pulse, `out_ready` held at 1.
  - Required: 64 consecutive transfers starting the cycle after the pulse; `out_re` = 4 for k 0–31 and 0 for k 32–63; `out_last` only at k = 63; then `busy` = 0 and `frame_count` = 1.
- Backpressure:
  - Stimulus: `outputRe`[i] = i, `outputIm`[i] = -i; `out_ready` toggles 1,0,0,1,…
  - Required: all 64 samples delivered in order with no duplicates; outputs stable during stalls.
- Bit-reversed order:
  - Stimulus: `BIT_REVERSE` = 1, `outputRe`[i] = i.
  - Required: k = 0,1,2,3 yields `out_re` = 0, 32, 16, 48; k = 63 yields 63.
- Overrun:
  - Stimulus: second `fft_done` at k = 10 with different data.
  - Required: the stream continues with the first frame's data; `overrun` = 1 from the next cycle until `rst`.
- Back-to-back:
  - Stimulus: `fft_done` coincident with the k = 63 transfer.
  - Required: the next cycle shows k = 0 with the new data and `out_valid` = 1; `overrun` = 0; `frame_count` = 1.
- Mid-stream reset:
  - Stimulus: `rst` at k = 20.
  - Required: next cycle `out_valid` = 0, `busy` = 0, `frame_count` = 0; the next `fft_done` restarts the stream at k = 0.

Source files
------------

// File: rtl/fft_result_streamer.sv
// ---------------------------------------------------------------------------
// fft_result_streamer
//
// Purpose:
//   Snapshots the parallel N-entry complex result arrays of the FFT into a
//   local frame buffer when fft_done pulses. It then streams the samples out
//   one per transfer over a valid/ready port, in natural or bit-reversed
//   order. The FFT can accept a new frame while results drain.
//
// Parameters:
//   N           points per frame (power of two, >= 4)
//   W           bits per real/imag component
//   BIT_REVERSE 0: sample k = buffer[k]; 1: sample k = buffer[bitrev(k)]
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   fft_done     in   one-cycle pulse; outputRe/outputIm valid that cycle
//   outputRe     in   N x W real results from the FFT
//   outputIm     in   N x W imaginary results from the FFT
//   out_valid    out  current sample is valid
//   out_ready    in   consumer accepts the current sample
//   out_re       out  real part of the current sample (0 when not valid)
//   out_im       out  imaginary part of the current sample (0 when not valid)
//   out_index    out  sample number k within the frame (0 when not valid)
//   out_last     out  high with out_valid when k = N-1
//   busy         out  a frame is held or streaming
//   overrun      out  sticky: a fft_done was dropped
//   frame_count  out  frames fully streamed, wraps 255 -> 0
// ---------------------------------------------------------------------------
module fft_result_streamer #(
  parameter int N           = 64,
  parameter int W           = 16,
  parameter int BIT_REVERSE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fft_done,
  input  logic [N-1:0][W-1:0]    outputRe,
  input  logic [N-1:0][W-1:0]    outputIm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [W-1:0]           out_re,
  output logic [W-1:0]           out_im,
  output logic [$clog2(N)-1:0]   out_index,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overrun,
  output logic [7:0]             frame_count
);

  localparam int KW = $clog2(N);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic            r_overrun;
  logic [7:0]      r_frame_count;

  // Frame buffer: every entry is written in the same cycle on capture, so it
  // is held in flops rather than a single-port RAM.
  logic [W-1:0]    r_buf_re [N];
  logic [W-1:0]    r_buf_im [N];

  logic            w_last_k;
  logic            w_final_xfer;
  logic            w_capture;
  logic [KW-1:0]   w_k_rev;
  logic [KW-1:0]   w_rd_addr;

  assign w_last_k     = (r_k == KW'(N - 1));
  assign w_final_xfer = (r_state == ST_STREAM) && out_ready && w_last_k;
  // A new frame is taken when idle, or when it lands exactly on the final
  // transfer of the current frame (back-to-back, no bubble).
  assign w_capture    = fft_done && ((r_state == ST_IDLE) || w_final_xfer);

  generate
    for (genvar gi = 0; gi < KW; gi++) begin : g_bitrev
      assign w_k_rev[gi] = r_k[KW-1-gi];
    end
  endgenerate

  assign w_rd_addr = (BIT_REVERSE != 0) ? w_k_rev : r_k;

  // Buffer is never reset; it only changes on capture.
  always_ff @(posedge clk) begin
    if (!rst && w_capture) begin
      for (int i = 0; i < N; i++) begin
        r_buf_re[i] <= outputRe[i];
        r_buf_im[i] <= outputIm[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_k           <= '0;
      r_overrun     <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fft_done) begin
            r_state <= ST_STREAM;
            r_k     <= '0;
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (w_last_k) begin
              r_frame_count <= r_frame_count + 8'd1;
              r_k           <= '0;
              if (!fft_done) begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
          if (fft_done && !w_final_xfer) begin
            r_overrun <= 1'b1;
          end
        end
      endcase
    end
  end

  // Outputs decode only from state, k and the buffer; nothing from
  // out_ready or fft_done reaches them combinationally.
  assign out_valid   = (r_state == ST_STREAM);
  assign busy        = out_valid;
  assign out_re      = out_valid ? r_buf_re[w_rd_addr] : '0;
  assign out_im      = out_valid ? r_buf_im[w_rd_addr] : '0;
  assign out_index   = out_valid ? r_k : '0;
  assign out_last    = out_valid && w_last_k;
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_fft_result_streamer.sv
// ---------------------------------------------------------------------------
// tb_fft_result_streamer
//
// Drives a natural-order and a bit-reversed instance with shared stimulus.
// Expected outputs come from a transaction-level model: each captured frame
// becomes a queue of expected samples; every accepted transfer pops one.
// ---------------------------------------------------------------------------
module tb_fft_result_streamer;

  localparam int N  = 64;
  localparam int W  = 16;
  localparam int KW = 6;

  typedef struct packed {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [KW-1:0] idx;
    logic          last;
  } samp_t;

  logic                clk;
  logic                rst;
  logic                fft_done;
  logic [N-1:0][W-1:0] in_re;
  logic [N-1:0][W-1:0] in_im;
  logic                out_ready;

  logic                a_valid, a_last, a_busy, a_overrun;
  logic [W-1:0]        a_re, a_im;
  logic [KW-1:0]       a_index;
  logic [7:0]          a_fc;

  logic                b_valid, b_last, b_busy, b_overrun;
  logic [W-1:0]        b_re, b_im;
  logic [KW-1:0]       b_index;
  logic [7:0]          b_fc;

  fft_result_streamer #(.N(N), .W(W), .BIT_REVERSE(0)) dut (
    .clk(clk), .rst(rst), .fft_done(fft_done),
    .outputRe(in_re), .outputIm(in_im),
    .out_valid(a_valid), .out_ready(out_ready),
    .out_re(a_re), .out_im(a_im), .out_index(a_index), .out_last(a_last),
    .busy(a_busy), .overrun(a_overrun), .frame_count(a_fc)
  );

  fft_result_streamer #(.N(N), .W(W), .BIT_REVERSE(1)) dut_br (
    .clk(clk), .rst(rst), .fft_done(fft_done),
    .outputRe(in_re), .outputIm(in_im),
    .out_valid(b_valid), .out_ready(out_ready),
    .out_re(b_re), .out_im(b_im), .out_index(b_index), .out_last(b_last),
    .busy(b_busy), .overrun(b_overrun), .frame_count(b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  samp_t      q_nat[$];
  samp_t      q_br[$];
  logic       m_overrun;
  logic [7:0] m_fc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < KW; b++) r |= ((k >> b) & 1) << (KW - 1 - b);
    return r;
  endfunction

  task automatic push_frame();
    samp_t s;
    for (int k = 0; k < N; k++) begin
      s.idx  = KW'(k);
      s.last = (k == N - 1);
      s.re   = in_re[k];
      s.im   = in_im[k];
      q_nat.push_back(s);
      s.re   = in_re[brev(k)];
      s.im   = in_im[brev(k)];
      q_br.push_back(s);
    end
  endtask

  // Advance the model by one clock edge with the inputs about to be sampled.
  task automatic model_edge(input logic r, input logic d, input logic rdy);
    samp_t s;
    if (r) begin
      q_nat.delete();
      q_br.delete();
      m_overrun = 1'b0;
      m_fc      = 8'd0;
      return;
    end
    if (q_nat.size() > 0 && rdy) begin
      s = q_nat.pop_front();
      void'(q_br.pop_front());
      if (s.last) begin
        m_fc = m_fc + 8'd1;
        $display("frame complete: frame_count=%0d", m_fc);
      end
    end
    if (d) begin
      if (q_nat.size() == 0) begin
        push_frame();
        $display("frame captured: re[0]=0x%0h re[1]=0x%0h", in_re[0], in_re[1]);
      end else begin
        m_overrun = 1'b1;
        $display("frame dropped while streaming");
      end
    end
  endtask

  task automatic check_outputs();
    samp_t ea, eb;
    logic  v;
    v  = (q_nat.size() > 0);
    ea = v ? q_nat[0] : '0;
    eb = v ? q_br[0]  : '0;
    check_val("valid",       32'(a_valid),   32'(v));
    check_val("busy",        32'(a_busy),    32'(v));
    check_val("re",          32'(a_re),      32'(ea.re));
    check_val("im",          32'(a_im),      32'(ea.im));
    check_val("index",       32'(a_index),   32'(ea.idx));
    check_val("last",        32'(a_last),    32'(ea.last));
    check_val("overrun",     32'(a_overrun), 32'(m_overrun));
    check_val("frame_count", 32'(a_fc),      32'(m_fc));
    check_val("br_valid",    32'(b_valid),   32'(v));
    check_val("br_re",       32'(b_re),      32'(eb.re));
    check_val("br_im",       32'(b_im),      32'(eb.im));
    check_val("br_index",    32'(b_index),   32'(eb.idx));
    check_val("br_last",     32'(b_last),    32'(eb.last));
    check_val("br_overrun",  32'(b_overrun), 32'(m_overrun));
    check_val("br_fc",       32'(b_fc),      32'(m_fc));
  endtask

  // Called just after a falling edge: apply inputs, advance the model,
  // wait for the next falling edge and compare.
  task automatic step(input logic r, input logic d, input logic rdy);
    rst       = r;
    fft_done  = d;
    out_ready = rdy;
    model_edge(r, d, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      in_re[i] = W'($urandom);
      in_im[i] = W'($urandom);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  // Stream with ready held high until the model head reaches index k.
  task automatic run_to_index(input int k);
    for (int c = 0; c < 4 * N && !(q_nat.size() > 0 && q_nat[0].idx == KW'(k)); c++)
      step(1'b0, 1'b0, 1'b1);
    check_val("reach_index", 32'(a_index), 32'(k));
  endtask

  task automatic drain(input int max_cycles);
    for (int c = 0; c < max_cycles && q_nat.size() > 0; c++)
      step(1'b0, 1'b0, 1'b1);
    check_val("drained", 32'(q_nat.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; fft_done = 1'b0; out_ready = 1'b0;
    in_re = '0; in_im = '0;
    m_overrun = 1'b0; m_fc = 8'd0;

    // Reset state
    do_reset();

    // Basic stream: re = 4 for the first half, 0 for the rest
    for (int i = 0; i < N; i++) begin
      in_re[i] = (i < 32) ? W'(4) : W'(0);
      in_im[i] = '0;
    end
    step(1'b0, 1'b1, 1'b1);
    drain(2 * N);
    step(1'b0, 1'b0, 1'b1);
    check_val("basic_fc", 32'(a_fc), 32'd1);

    // Backpressure with ready pattern 1,0,0 repeating; ramp data
    for (int i = 0; i < N; i++) begin
      in_re[i] = W'(i);
      in_im[i] = W'(-i);
    end
    step(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 4 * N && q_nat.size() > 0; c++)
      step(1'b0, 1'b0, (c % 3) == 0);
    check_val("bp_drained", 32'(q_nat.size()), 32'd0);

    // Overrun: second fft_done at k = 10 with different data
    fill_random();
    step(1'b0, 1'b1, 1'b1);
    run_to_index(10);
    fill_random();
    step(1'b0, 1'b1, 1'b1);
    drain(2 * N);
    step(1'b0, 1'b0, 1'b0);
    check_val("overrun_sticky", 32'(a_overrun), 32'd1);

    // Back-to-back: fft_done coincident with the k = N-1 transfer
    do_reset();
    fill_random();
    step(1'b0, 1'b1, 1'b1);
    run_to_index(N - 1);
    fill_random();
    step(1'b0, 1'b1, 1'b1);
    check_val("b2b_valid", 32'(a_valid), 32'd1);
    check_val("b2b_index", 32'(a_index), 32'd0);
    check_val("b2b_fc",    32'(a_fc),    32'd1);
    drain(2 * N);

    // Mid-stream reset at k = 20, then restart
    fill_random();
    step(1'b0, 1'b1, 1'b1);
    run_to_index(20);
    step(1'b1, 1'b0, 1'b1);
    check_val("rst_valid", 32'(a_valid), 32'd0);
    check_val("rst_fc",    32'(a_fc),    32'd0);
    step(1'b0, 1'b0, 1'b1);
    fill_random();
    step(1'b0, 1'b1, 1'b1);
    check_val("restart_index", 32'(a_index), 32'd0);
    drain(2 * N);

    // Randomized phase: random data every cycle, random ready/done/reset
    for (int c = 0; c < 3000; c++) begin
      fill_random();
      step($urandom_range(0, 599) == 0,
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
